// File: rtl/bp_pkg.sv
// Shared branch-prediction types and helpers.
//   addr_t    : 32-bit instruction address
//   state_t   : return-PC table sweep FSM states
//   meta_t    : one table entry (valid bit + tag)
//   get_index : set index = pc[2+index_bits-1:2] (zero-extended)
//   get_tag   : tag = pc[31:2+index_bits] (zero-extended to TAG_MAX bits)
package bp_pkg;

    typedef logic [31:0] addr_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Widest possible tag (one index bit). Narrower tags are stored
    // zero-extended, so equality compares remain exact.
    localparam int TAG_MAX = 29;

    typedef struct packed {
        logic               valid;
        logic [TAG_MAX-1:0] tag;
    } meta_t;

    function automatic addr_t get_index(input addr_t pc, input int index_bits);
        addr_t mask;
        mask = (addr_t'(1) << index_bits) - addr_t'(1);
        return (pc >> 2) & mask;
    endfunction

    function automatic logic [TAG_MAX-1:0] get_tag(input addr_t pc, input int index_bits);
        addr_t shifted;
        shifted = pc >> (2 + index_bits);
        return shifted[TAG_MAX-1:0];
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set, purely combinational.
//   plru_bits : current node bits, node n has children 2n+1 / 2n+2
//   touch_way : way being marked most-recently-used
//   victim    : way selected by walking the tree (0 = left, 1 = right)
//   plru_next : node bits after touching touch_way; every node on the
//               path points away from it (went left -> 1, right -> 0)
module plru_tree #(
    parameter int WAYS = 4,
    localparam int WAY_BITS = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]     plru_bits,
    input  logic [WAY_BITS-1:0] touch_way,
    output logic [WAY_BITS-1:0] victim,
    output logic [WAYS-2:0]     plru_next
);

    // Only internal nodes (0..WAYS-2) are ever used as an index, so a
    // WAY_BITS-wide node number is enough; the child computed after the
    // last level overflows harmlessly and is never read.
    always_comb begin
        logic [WAY_BITS-1:0] node;
        logic                dir;
        node   = '0;
        dir    = 1'b0;
        victim = '0;
        for (int l = 0; l < WAY_BITS; l++) begin
            dir = plru_bits[node];
            victim[WAY_BITS-1-l] = dir;
            node = (node << 1) + WAY_BITS'(1) + WAY_BITS'(dir);
        end
    end

    // The way number read MSB-first is the left/right path from the root.
    always_comb begin
        logic [WAY_BITS-1:0] node;
        logic                dir;
        node      = '0;
        dir       = 1'b0;
        plru_next = plru_bits;
        for (int l = 0; l < WAY_BITS; l++) begin
            dir = touch_way[WAY_BITS-1-l];
            plru_next[node] = ~dir;
            node = (node << 1) + WAY_BITS'(1) + WAY_BITS'(dir);
        end
    end

endmodule

// File: rtl/rpct_nway.sv
// N-way set-associative return-PC table. Remembers the PCs of jr $ra /
// jalr instructions so fetch can flag them early.
//   clk, reset    : clock, synchronous active-high reset
//   init_busy     : 1 while the clearing sweep runs (state INIT)
//   lookup_valid  : fetch lookup request, lookup_pc = PC of slot 0
//   hit           : per-slot hit for pc + 4k, combinational
//   upd_valid     : execute update, upd_inval selects invalidate/insert
//   upd_pc        : PC of the jr/jalr being updated
//   flush         : restart the clearing sweep
//
// Request semantics: lookup_valid and upd_valid are single-cycle requests
// with no ready; in RUN they are always accepted at the next posedge, in
// INIT (and in a cycle with flush or reset) they are dropped without any
// state change. Writes are visible to lookups from the following cycle.
module rpct_nway
    import bp_pkg::*;
#(
    parameter int ASSOCIATIVITY = 4,
    parameter int SET_NUM       = 16,
    parameter int FETCH_WIDTH   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   init_busy,
    input  logic                   lookup_valid,
    input  addr_t                  lookup_pc,
    output logic [FETCH_WIDTH-1:0] hit,
    input  logic                   upd_valid,
    input  logic                   upd_inval,
    input  addr_t                  upd_pc,
    input  logic                   flush
);

    localparam int INDEX_BITS = $clog2(SET_NUM);
    localparam int WAY_BITS   = $clog2(ASSOCIATIVITY);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    meta_t                    meta [SET_NUM][ASSOCIATIVITY];
    logic [ASSOCIATIVITY-2:0] plru [SET_NUM];

    // ------------------------------------------------------------------
    // Sweep FSM
    // ------------------------------------------------------------------
    state_t                  state, state_nxt;
    logic [INDEX_BITS-1:0]   sweep_cnt, sweep_cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            sweep_cnt <= '0;
        end else begin
            state     <= state_nxt;
            sweep_cnt <= sweep_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sweep_cnt_nxt = sweep_cnt;
        if (flush) begin
            state_nxt     = INIT;
            sweep_cnt_nxt = '0;
        end else if (state == INIT) begin
            sweep_cnt_nxt = sweep_cnt + INDEX_BITS'(1);
            if (sweep_cnt == INDEX_BITS'(SET_NUM - 1)) begin
                state_nxt = RUN;
            end
        end
    end

    assign init_busy = (state == INIT);

    // Table changes are only allowed in RUN and never in a cycle that is
    // itself restarting the sweep.
    logic run_write;
    assign run_write = (state == RUN) && !reset && !flush;

    // ------------------------------------------------------------------
    // Lookup: one read port per slot
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0]    slot_idx      [FETCH_WIDTH];
    logic [TAG_MAX-1:0]       slot_tag      [FETCH_WIDTH];
    logic [ASSOCIATIVITY-1:0] slot_way_hit  [FETCH_WIDTH];

    always_comb begin
        addr_t spc;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            spc         = lookup_pc + addr_t'(4 * k);
            slot_idx[k] = INDEX_BITS'(get_index(spc, INDEX_BITS));
            slot_tag[k] = get_tag(spc, INDEX_BITS);
            for (int w = 0; w < ASSOCIATIVITY; w++) begin
                slot_way_hit[k][w] = meta[slot_idx[k]][w].valid &&
                                     (meta[slot_idx[k]][w].tag == slot_tag[k]);
            end
            hit[k] = lookup_valid && (state == RUN) && (|slot_way_hit[k]);
        end
    end

    // Lowest hitting slot wins the single PLRU touch port; the descending
    // scans let lower slots / ways overwrite higher ones.
    logic                  lk_touch;
    logic [INDEX_BITS-1:0] lk_set;
    logic [WAY_BITS-1:0]   lk_way;

    always_comb begin
        lk_touch = |hit;
        lk_set   = '0;
        lk_way   = '0;
        for (int k = FETCH_WIDTH - 1; k >= 0; k--) begin
            if (hit[k]) begin
                lk_set = slot_idx[k];
                for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
                    if (slot_way_hit[k][w]) begin
                        lk_way = WAY_BITS'(w);
                    end
                end
            end
        end
    end

    logic [ASSOCIATIVITY-2:0] lk_plru_cur, lk_plru_next;
    logic [WAY_BITS-1:0]      lk_victim_unused;

    assign lk_plru_cur = plru[lk_set];

    plru_tree #(.WAYS(ASSOCIATIVITY)) u_lk_tree (
        .plru_bits (lk_plru_cur),
        .touch_way (lk_way),
        .victim    (lk_victim_unused),
        .plru_next (lk_plru_next)
    );

    // ------------------------------------------------------------------
    // Update: insert / invalidate
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0]    upd_idx;
    logic [TAG_MAX-1:0]       upd_tag;
    logic                     upd_match_any, upd_inv_any;
    logic [WAY_BITS-1:0]      upd_match_way, upd_inv_way, upd_victim, upd_way;
    logic [ASSOCIATIVITY-2:0] upd_plru_cur, upd_plru_next;

    assign upd_idx      = INDEX_BITS'(get_index(upd_pc, INDEX_BITS));
    assign upd_tag      = get_tag(upd_pc, INDEX_BITS);
    assign upd_plru_cur = plru[upd_idx];

    always_comb begin
        upd_match_any = 1'b0;
        upd_match_way = '0;
        upd_inv_any   = 1'b0;
        upd_inv_way   = '0;
        for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
            if (meta[upd_idx][w].valid && (meta[upd_idx][w].tag == upd_tag)) begin
                upd_match_any = 1'b1;
                upd_match_way = WAY_BITS'(w);
            end
            if (!meta[upd_idx][w].valid) begin
                upd_inv_any = 1'b1;
                upd_inv_way = WAY_BITS'(w);
            end
        end
        // Re-inserting a resident PC only refreshes it; otherwise fill a
        // free way before evicting anything.
        if (upd_match_any) begin
            upd_way = upd_match_way;
        end else if (upd_inv_any) begin
            upd_way = upd_inv_way;
        end else begin
            upd_way = upd_victim;
        end
    end

    plru_tree #(.WAYS(ASSOCIATIVITY)) u_upd_tree (
        .plru_bits (upd_plru_cur),
        .touch_way (upd_way),
        .victim    (upd_victim),
        .plru_next (upd_plru_next)
    );

    // ------------------------------------------------------------------
    // Table write port. The sweep has no reset of its own: reset only
    // restarts the FSM, which then clears one set per cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT) begin
                for (int w = 0; w < ASSOCIATIVITY; w++) begin
                    meta[sweep_cnt][w] <= '0;
                end
                plru[sweep_cnt] <= '0;
            end else if (run_write) begin
                // Lookup touch first so an update to the same set overrides it.
                if (lk_touch) begin
                    plru[lk_set] <= lk_plru_next;
                end
                if (upd_valid) begin
                    if (upd_inval) begin
                        if (upd_match_any) begin
                            meta[upd_idx][upd_match_way].valid <= 1'b0;
                        end
                    end else begin
                        meta[upd_idx][upd_way] <= '{valid: 1'b1, tag: upd_tag};
                        plru[upd_idx]          <= upd_plru_next;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rpct_nway.sv
// Directed bench for rpct_nway (A=4, S=16, FW=2, index = pc[5:2]).
module tb_rpct_nway;
    import bp_pkg::*;

    localparam int FW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          init_busy;
    logic          lookup_valid = 1'b0;
    addr_t         lookup_pc = '0;
    logic [FW-1:0] hit;
    logic          upd_valid = 1'b0;
    logic          upd_inval = 1'b0;
    addr_t         upd_pc = '0;
    logic          flush = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    rpct_nway #(
        .ASSOCIATIVITY (4),
        .SET_NUM       (16),
        .FETCH_WIDTH   (FW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .init_busy    (init_busy),
        .lookup_valid (lookup_valid),
        .lookup_pc    (lookup_pc),
        .hit          (hit),
        .upd_valid    (upd_valid),
        .upd_inval    (upd_inval),
        .upd_pc       (upd_pc),
        .flush        (flush)
    );

    // ---------------- scoreboard ----------------
    // Each entry is {init_busy, hit} expected in a lookup cycle.
    logic [FW:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [FW:0] exp_v;
    string       exp_n;

    always @(negedge clk) begin
        if (lookup_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_lookup: got busy=%0b hit=%b with no expectation queued",
                         init_busy, hit);
            end else begin
                exp_v = exp_q.pop_front();
                exp_n = name_q.pop_front();
                if ({init_busy, hit} !== exp_v) begin
                    failures++;
                    $display("FAIL %s: got busy=%0b hit=%b, want busy=%0b hit=%b",
                             exp_n, init_busy, hit, exp_v[FW], exp_v[FW-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic lv, input addr_t lpc, input logic uv, input logic ui,
                        input addr_t upc, input logic fl, input logic eb,
                        input logic [FW-1:0] eh, input string nm);
        lookup_valid = lv;
        lookup_pc    = lpc;
        upd_valid    = uv;
        upd_inval    = ui;
        upd_pc       = upc;
        flush        = fl;
        if (lv) begin
            exp_q.push_back({eb, eh});
            name_q.push_back(nm);
        end
        @(posedge clk);
        #1;
        lookup_valid = 1'b0;
        upd_valid    = 1'b0;
        upd_inval    = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic look(input addr_t pc, input logic [FW-1:0] eh, input string nm);
        step(1'b1, pc, 1'b0, 1'b0, '0, 1'b0, 1'b0, eh, nm);
    endtask

    task automatic ins(input addr_t pc);
        step(1'b0, '0, 1'b1, 1'b0, pc, 1'b0, 1'b0, '0, "");
    endtask

    task automatic inv(input addr_t pc);
        step(1'b0, '0, 1'b1, 1'b1, pc, 1'b0, 1'b0, '0, "");
    endtask

    // n cycles of lookups that must see the sweep running, then one that
    // must see it finished.
    task automatic sweep_check(input int n, input addr_t pc, input string nm);
        for (int i = 0; i < n; i++) begin
            step(1'b1, pc, 1'b0, 1'b0, '0, 1'b0, 1'b1, 2'b00, $sformatf("%s_busy%0d", nm, i));
        end
        step(1'b1, pc, 1'b0, 1'b0, '0, 1'b0, 1'b0, 2'b00, $sformatf("%s_done", nm));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        @(posedge clk);
        #1;
        // Reset held: INIT, no hits.
        step(1'b1, 32'h0000_0040, 1'b0, 1'b0, '0, 1'b0, 1'b1, 2'b00, "reset_state");
        reset = 1'b0;

        // Sweep after reset: 16 busy cycles, an insert during it is dropped.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 32'h8000_0040, (i == 3), 1'b0, 32'h8000_0040, 1'b0, 1'b1, 2'b00,
                 $sformatf("reset_sweep_busy%0d", i));
        end
        look(32'h8000_0040, 2'b00, "sweep_insert_dropped");

        // Slot matching; same-cycle lookup does not see the insert.
        step(1'b1, 32'h8000_0040, 1'b1, 1'b0, 32'h8000_0040, 1'b0, 1'b0, 2'b00, "no_bypass");
        look(32'h8000_003C, 2'b10, "slot1_hit");
        look(32'h8000_0040, 2'b01, "slot0_hit");
        look(32'h8000_0044, 2'b00, "past_slot_miss");

        // Flush in RUN with the table populated (lookup in the flush cycle still hits).
        step(1'b1, 32'h8000_0040, 1'b0, 1'b0, '0, 1'b1, 1'b0, 2'b01, "flush_cycle_hit");
        sweep_check(16, 32'h8000_0040, "flush_run");

        // Replacement in set 0.
        ins(32'h0000_0000);
        ins(32'h0000_0040);
        ins(32'h0000_0080);
        ins(32'h0000_00C0);
        look(32'h0000_0000, 2'b01, "repl_touch0");
        ins(32'h0000_0100);
        look(32'h0000_0080, 2'b00, "repl_evicted_80");
        look(32'h0000_0000, 2'b01, "repl_keep_00");
        look(32'h0000_0040, 2'b01, "repl_keep_40");
        look(32'h0000_00C0, 2'b01, "repl_keep_C0");
        look(32'h0000_0100, 2'b01, "repl_new_100");
        look(32'hFFFF_FFFC, 2'b10, "pc_wrap_slot1");

        // reset together with flush behaves like reset.
        reset = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 2'b00, "");
        reset = 1'b0;
        sweep_check(16, 32'h0000_0000, "reset_flush");

        // Duplicate inserts do not allocate; re-insert of 0x240 refreshes way 1.
        ins(32'h0000_0200);
        ins(32'h0000_0200);
        ins(32'h0000_0240);
        ins(32'h0000_0280);
        ins(32'h0000_02C0);
        ins(32'h0000_0240);
        look(32'h0000_0200, 2'b01, "dup_200");
        look(32'h0000_0240, 2'b01, "dup_240");
        look(32'h0000_0280, 2'b01, "dup_280");
        look(32'h0000_02C0, 2'b01, "dup_2C0");

        // Invalidate.
        inv(32'h0000_0240);
        look(32'h0000_0240, 2'b00, "inval_240_gone");
        look(32'h0000_0200, 2'b01, "inval_keep_200");
        look(32'h0000_0280, 2'b01, "inval_keep_280");
        look(32'h0000_02C0, 2'b01, "inval_keep_2C0");
        inv(32'h0000_0300);
        look(32'h0000_0200, 2'b01, "inval_absent_noop");
        // Freed way is reused ahead of the PLRU victim (way 2 = 0x280).
        ins(32'h0000_0340);
        look(32'h0000_0340, 2'b01, "refill_340");
        look(32'h0000_0200, 2'b01, "refill_keep_200");
        look(32'h0000_0280, 2'b01, "refill_keep_280");
        look(32'h0000_02C0, 2'b01, "refill_keep_2C0");

        // Flush, then flush again at sweep cycle 7: 16 more busy cycles.
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 2'b00, "");
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 32'h0000_0200, 1'b0, 1'b0, '0, (i == 6), 1'b1, 2'b00,
                 $sformatf("midflush_first_busy%0d", i));
        end
        sweep_check(16, 32'h0000_0200, "midflush_restart");
        look(32'h0000_0340, 2'b00, "after_flush_miss");

        // Every queued expectation must have been consumed.
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d leftover expectations, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rpct_nway.md
Name: rpct_nway

Overview:
- N-way set-associative return-PC table (RPCT) that records the PCs of `jr $ra` / `jalr` instructions.
- The fetch stage looks up a bundle of consecutive PCs and gets one hit bit per slot; the execute stage inserts or invalidates entries.
- Generalised over the 2-way, single-slot table: tree-PLRU for any power-of-two associativity, multi-slot lookup, invalidate and flush.
- A sweep FSM clears the table after reset and after flush.

Parameters:
- ASSOCIATIVITY, 4, ways per set; power of two, at least 2.
- SET_NUM, 16, number of sets; power of two, at least 2.
- FETCH_WIDTH, 2, consecutive PC slots checked per lookup (slot k = pc + 4k).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- init_busy  out  1  sweep in progress
- lookup_valid  in  1  lookup request
- lookup_pc  in  32  (addr_t) PC of slot 0
- hit  out  FETCH_WIDTH  per-slot hit, combinational
- upd_valid  in  1  update request from execute
- upd_inval  in  1  1 = invalidate, 0 = insert
- upd_pc  in  32  (addr_t) PC of the jr/jalr
- flush  in  1  restart the clearing sweep

Behaviour:
- Address split: INDEX_BITS = log2(SET_NUM); index = pc[2+INDEX_BITS-1:2]; tag = pc[31:2+INDEX_BITS]. pc[1:0] is ignored.
- Entry: valid bit plus tag. Each set also holds ASSOCIATIVITY-1 PLRU bits.
- FSM has two states, INIT and RUN.
  - reset forces INIT with the sweep counter at 0.
  - In INIT, one set per cycle is cleared (all valid bits = 0, PLRU bits = 0); after set SET_NUM-1 the FSM moves to RUN.
  - Total sweep = SET_NUM cycles after reset deasserts.
  - flush in either state enters INIT with the counter at 0 (a sweep in progress restarts). reset has priority over flush.
- init_busy = 1 exactly while in INIT; reset value is 1.
- While in INIT: hit = 0, and all updates and lookups are dropped with no state change.
- Lookup (read latency 0):
  - hit[k] = lookup_valid & RUN & (some way in set index(pc+4k) is valid with a matching tag).
  - Each slot reads its own set, so the table has FETCH_WIDTH read ports. pc+4k is computed modulo 2^32.
- PLRU touch on lookup: at the next posedge, the lowest-k hitting slot touches its set and way. Only one touch per cycle.
- Insert (upd_valid & ~upd_inval & RUN), applied at posedge:
  - If the tag is already present and valid in the set: no allocation, touch that way.
  - Otherwise, victim = lowest-numbered invalid way; if none is invalid, the PLRU victim. Write valid=1 and the tag, then touch the victim.
- Invalidate (upd_valid & upd_inval & RUN): clear the valid bit of the matching way at posedge. PLRU is unchanged. A miss is a no-op.
- Writes become visible to lookups in the following cycle; there is no same-cycle bypass.
- If an update and a lookup touch the same set in one cycle, the update's PLRU result wins. Touches to different sets both apply.
- Tree PLRU:
  - Nodes are 0..A-2; node n has children 2n+1 and 2n+2; leaves in order map to ways 0..A-1.
  - Victim walk: bit 0 → go left, bit 1 → go right.
  - Touching way w sets every node on its path to point away from w: went left → 1, went right → 0.

Decomposition:
- Shared package bp_pkg holds addr_t, the rpct meta_t struct (valid, tag) and index/tag extraction functions parameterised by INDEX_BITS.
- One sub-module, plru_tree: combinational victim-select and touch-update for ASSOCIATIVITY-1 bits.
- Meta and PLRU storage are flop arrays inside rpct_nway.

Test Plan (defaults A=4, S=16, FW=2, so index = pc[5:2]):
- Reset sweep: deassert reset → init_busy = 1 for exactly 16 cycles, then 0. During the sweep, hit = 2'b00 for any lookup, and an insert of 0x8000_0040 issued during the sweep does not later hit.
- Slot matching: insert 0x8000_0040; next cycle lookup 0x8000_003C → hit = 2'b10; lookup 0x8000_0040 → 2'b01; lookup 0x8000_0044 → 2'b00. A lookup in the same cycle as the insert → 2'b00.
- Replacement:
  - Insert 0x00, 0x40, 0x80, 0xC0 into set 0 (fills ways 0–3; PLRU bits end at 000).
  - Lookup 0x00 → PLRU bits become n0=1, n1=1.
  - Insert 0x100 → victim is way 2 (0x80 evicted): lookup 0x80 → miss; 0x00, 0x40, 0xC0, 0x100 → hit.
- Duplicate insert: insert 0x200 twice, then 0x240, 0x280, 0xC0+0x200 (0x2C0) → all four hit; no eviction occurs.
- Invalidate: with 0x40 resident, issue upd_inval with pc 0x40 → next-cycle lookup 0x40 misses, other ways still hit. Invalidating an absent PC changes nothing.
- Flush and reset mid-sweep:
  - Flush in RUN with the table populated → init_busy = 1 for 16 cycles, then all lookups miss.
  - Flush at sweep cycle 7 → init_busy lasts 16 more cycles.
  - reset and flush together → identical to reset alone.
